// File: rtl/foc_pkg.sv
// Shared types and constants for the FOC loop scheduler.
// State encoding, fault codes and a constant-width helper.
package foc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ARMED,
    CDT,
    CL,
    FAULT
  } focState_e;

  localparam logic [1:0] FLT_NONE   = 2'd0;
  localparam logic [1:0] FLT_CDT_TO = 2'd1;
  localparam logic [1:0] FLT_CL_TO  = 2'd2;
  localparam logic [1:0] FLT_PLL    = 2'd3;

  function automatic int maxOf3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/foc_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module foc_sat_counter #(
  parameter int W = 16
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iClr,
  input  logic         iInc,
  output logic [W-1:0] oCnt
);

  logic [W-1:0] cnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt <= '0;
    end else if (iClr) begin
      cnt <= '0;
    end else if (iInc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign oCnt = cnt;

endmodule

// File: rtl/foc_loop_scheduler.sv
// Period-locked FOC iteration scheduler: encoder read, then current loop.
// Adds stage timeouts, overrun counting, PLL-loss shutdown.
module foc_loop_scheduler
  import foc_pkg::*;
#(
  parameter int CDT_TIMEOUT = 2000,
  parameter int CL_TIMEOUT  = 8000,
  parameter int LOCK_SETTLE = 256,
  parameter int CNT_W       = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iRun,
  input  logic             iPll_locked,
  input  logic             iPwm_sync,
  input  logic             iCdt_done,
  input  logic             iMod_done,
  input  logic             iFault_clr,
  output logic             oCdt_en,
  output logic             oCl_en,
  output logic             oSD_n,
  output logic             oBusy,
  output logic             oFault,
  output logic [1:0]       oFault_code,
  output logic [CNT_W-1:0] oOverrun_cnt
);

  localparam int TMAX = maxOf3(CDT_TIMEOUT, CL_TIMEOUT, LOCK_SETTLE);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] SETTLE_END = TW'(LOCK_SETTLE - 1);
  localparam logic [TW-1:0] CDT_END    = TW'(CDT_TIMEOUT);
  localparam logic [TW-1:0] CL_END     = TW'(CL_TIMEOUT);

  focState_e     state;
  focState_e     nextState;
  logic [1:0]    nextCode;
  logic [TW-1:0] tmrVal;
  logic          tmrClr;
  logic          cdtStart;
  logic          clStart;
  logic          ovrInc;

  foc_sat_counter #(.W(TW)) uTmr (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iClr  (tmrClr),
    .iInc  (1'b1),
    .oCnt  (tmrVal)
  );

  foc_sat_counter #(.W(CNT_W)) uOvrCnt (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iClr  (1'b0),
    .iInc  (ovrInc),
    .oCnt  (oOverrun_cnt)
  );

  always_comb begin
    nextState = state;
    nextCode  = oFault_code;
    tmrClr    = 1'b0;
    cdtStart  = 1'b0;
    clStart   = 1'b0;
    ovrInc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (iRun) begin
          nextState = SETTLE;
          tmrClr    = 1'b1;
        end
      end
      SETTLE: begin
        if (!iRun) begin
          nextState = IDLE;
        end else if (!iPll_locked) begin
          tmrClr = 1'b1;
        end else if (tmrVal >= SETTLE_END) begin
          nextState = ARMED;
        end
      end
      ARMED: begin
        if (!iPll_locked) begin
          nextState = FAULT;
          nextCode  = FLT_PLL;
        end else if (iPwm_sync) begin
          nextState = CDT;
          cdtStart  = 1'b1;
          tmrClr    = 1'b1;
        end else if (!iRun) begin
          nextState = IDLE;
        end
      end
      CDT: begin
        if (!iPll_locked) begin
          nextState = FAULT;
          nextCode  = FLT_PLL;
        end else begin
          ovrInc = iPwm_sync;
          if (iCdt_done) begin
            nextState = CL;
            clStart   = 1'b1;
            tmrClr    = 1'b1;
          end else if (tmrVal >= CDT_END) begin
            nextState = FAULT;
            nextCode  = FLT_CDT_TO;
          end
        end
      end
      CL: begin
        if (!iPll_locked) begin
          nextState = FAULT;
          nextCode  = FLT_PLL;
        end else if (iMod_done) begin
          // a sync landing on completion starts the next iteration
          if (iPwm_sync) begin
            nextState = CDT;
            cdtStart  = 1'b1;
            tmrClr    = 1'b1;
          end else if (iRun) begin
            nextState = ARMED;
          end else begin
            nextState = IDLE;
          end
        end else begin
          ovrInc = iPwm_sync;
          if (tmrVal >= CL_END) begin
            nextState = FAULT;
            nextCode  = FLT_CL_TO;
          end
        end
      end
      FAULT: begin
        if (iFault_clr && !iRun) begin
          nextState = IDLE;
          nextCode  = FLT_NONE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= IDLE;
      oCdt_en     <= 1'b0;
      oCl_en      <= 1'b0;
      oSD_n       <= 1'b0;
      oBusy       <= 1'b0;
      oFault      <= 1'b0;
      oFault_code <= FLT_NONE;
    end else begin
      state       <= nextState;
      oCdt_en     <= cdtStart;
      oCl_en      <= clStart;
      oSD_n       <= (state == ARMED) || (state == CDT) || (state == CL);
      oBusy       <= (state == CDT) || (state == CL);
      oFault      <= (nextState == FAULT);
      oFault_code <= nextCode;
    end
  end

endmodule
